// File: rtl/inner_ctl.sv
// inner_ctl: blitter inner-loop (pixels-per-line) controller below the outer sequencer.
// Latency: instart -> inner_busy 1 cycle; final step -> indone 1 cycle; restart on indone costs no dead cycle.
// Backpressure: none; step gaps simply hold the counter, and instart always wins over step.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   gpu_din[CW-1:0]         GPU write data, inner count field
//   countld                 load strobe for the inner count reload register
//   instart                 start/restart an inner pass
//   step                    one pixel completed this cycle
//   indone                  registered one-cycle pulse, inner pass complete
//   inner_busy              high while a pass is in progress
//   icount[CW-1:0]          live working counter
//   ilast                   combinational, the next step completes the pass
// Optional (macro INNER_CTL_STAT_EN):
//   statrd                  status read strobe
//   gpu_dout_out[CW-1:0]    live count driven towards the GPU bus
//   gpu_dout_oe             output enable for gpu_dout_out

module inner_ctl #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CW-1:0] gpu_din,
  input  logic          countld,
  input  logic          instart,
  input  logic          step,
`ifdef INNER_CTL_STAT_EN
  input  logic          statrd,
  output logic [CW-1:0] gpu_dout_out,
  output logic          gpu_dout_oe,
`endif
  output logic          indone,
  output logic          inner_busy,
  output logic [CW-1:0] icount,
  output logic          ilast
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] ireload;
  logic [CW-1:0] icount_q;
  logic          indone_q;
  logic [CW-1:0] reload_val;
  logic          cnt_is_one;

  // A load in the same cycle as a start bypasses the reload register so the
  // GPU can program and launch a line in one edge.
  assign reload_val = countld ? gpu_din : ireload;
  assign cnt_is_one = (icount_q == CW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ireload  <= '0;
      icount_q <= '0;
      indone_q <= 1'b0;
    end else begin
      indone_q <= 1'b0;

      if (countld) begin
        ireload <= gpu_din;
      end

      if (instart) begin
        // Start or restart; any step this cycle belongs to the aborted pass
        // and is dropped, so that pass never signals completion.
        icount_q <= reload_val;
        state    <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (step) begin
              if (cnt_is_one) begin
                icount_q <= '0;
                state    <= IDLE;
                indone_q <= 1'b1;
              end else begin
                // A reload of 0 wraps to all-ones here, giving 2^CW steps.
                icount_q <= icount_q - CW'(1);
              end
            end
          end
          default: begin
            // IDLE: steps are ignored and the count holds.
          end
        endcase
      end
    end
  end

  assign indone     = indone_q;
  assign inner_busy = (state == RUN);
  assign icount     = icount_q;
  assign ilast      = inner_busy & cnt_is_one;

`ifdef INNER_CTL_STAT_EN
  // Status read-back is purely combinational; the bus owner muxes on oe.
  assign gpu_dout_out = icount_q;
  assign gpu_dout_oe  = statrd;
`endif

endmodule

// File: tb/tb_inner_ctl.sv
module tb_inner_ctl;

  localparam int CW = 16;

  logic          clk;
  logic          reset_n;
  logic [CW-1:0] gpu_din;
  logic          countld;
  logic          instart;
  logic          step;
  logic          indone;
  logic          inner_busy;
  logic [CW-1:0] icount;
  logic          ilast;
`ifdef INNER_CTL_STAT_EN
  logic          statrd;
  logic [CW-1:0] gpu_dout_out;
  logic          gpu_dout_oe;
`endif

  int passed = 0;
  int total  = 0;
  int done_pulses = 0;
  int base;

  inner_ctl #(.CW(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .gpu_din    (gpu_din),
    .countld    (countld),
    .instart    (instart),
    .step       (step),
`ifdef INNER_CTL_STAT_EN
    .statrd       (statrd),
    .gpu_dout_out (gpu_dout_out),
    .gpu_dout_oe  (gpu_dout_oe),
`endif
    .indone     (indone),
    .inner_busy (inner_busy),
    .icount     (icount),
    .ilast      (ilast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which indone is high.
  always @(negedge clk) begin
    if (indone === 1'b1) done_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one rising edge, then settle just after it.
  task automatic drive(input logic ld, input logic [CW-1:0] d, input logic st, input logic sp);
    countld = ld;
    gpu_din = d;
    instart = st;
    step    = sp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    gpu_din = '0;
    countld = 1'b0;
    instart = 1'b0;
    step    = 1'b0;
`ifdef INNER_CTL_STAT_EN
    statrd  = 1'b0;
`endif
    #3;
    check("rst_icount", 32'(icount), 32'd0);
    check("rst_busy", 32'(inner_busy), 32'd0);
    check("rst_indone", 32'(indone), 32'd0);
    check("rst_ilast", 32'(ilast), 32'd0);
    #9;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Steps while idle are ignored.
    repeat (5) drive(1'b0, '0, 1'b0, 1'b1);
    check("idle_icount", 32'(icount), 32'd0);
    check("idle_busy", 32'(inner_busy), 32'd0);
    check("idle_done", 32'(done_pulses), 32'd0);

    // Basic pass of 3.
    base = done_pulses;
    drive(1'b1, 16'd3, 1'b0, 1'b0);
    check("basic_ld_busy", 32'(inner_busy), 32'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("basic_start_icount", 32'(icount), 32'd3);
    check("basic_start_busy", 32'(inner_busy), 32'd1);
    check("basic_start_ilast", 32'(ilast), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("basic_s1_icount", 32'(icount), 32'd2);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("basic_s2_icount", 32'(icount), 32'd1);
    check("basic_s2_ilast", 32'(ilast), 32'd1);
    check("basic_s2_indone", 32'(indone), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("basic_s3_icount", 32'(icount), 32'd0);
    check("basic_s3_indone", 32'(indone), 32'd1);
    check("basic_s3_busy", 32'(inner_busy), 32'd0);
    check("basic_s3_ilast", 32'(ilast), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("basic_after_indone", 32'(indone), 32'd0);
    check("basic_after_busy", 32'(inner_busy), 32'd0);
    check("basic_pulses", 32'(done_pulses - base), 32'd1);

    // Stalled pass of 4 (load and start together: bypass path).
    base = done_pulses;
    drive(1'b1, 16'd4, 1'b1, 1'b0);
    check("stall_start_icount", 32'(icount), 32'd4);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("stall_hold_icount", 32'(icount), 32'd3);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("stall_c6_icount", 32'(icount), 32'd1);
    check("stall_c6_indone", 32'(indone), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("stall_c7_indone", 32'(indone), 32'd1);
    check("stall_c7_icount", 32'(icount), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("stall_pulses", 32'(done_pulses - base), 32'd1);

    // Back-to-back lines of 2, restarting while indone is high.
    base = done_pulses;
    drive(1'b1, 16'd2, 1'b1, 1'b0);
    check("b2b_start_icount", 32'(icount), 32'd2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      check("b2b_s1_icount", 32'(icount), 32'd1);
      check("b2b_s1_indone", 32'(indone), 32'd0);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("b2b_s2_indone", 32'(indone), 32'd1);
      check("b2b_s2_icount", 32'(icount), 32'd0);
      if (i < 2) begin
        drive(1'b0, '0, 1'b1, 1'b0);
        check("b2b_re_busy", 32'(inner_busy), 32'd1);
        check("b2b_re_icount", 32'(icount), 32'd2);
        check("b2b_re_indone", 32'(indone), 32'd0);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("b2b_pulses", 32'(done_pulses - base), 32'd3);

    // Restart with bypass, load and step all in one cycle.
    base = done_pulses;
    drive(1'b1, 16'd7, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("rs_pre_icount", 32'(icount), 32'd5);
    drive(1'b1, 16'd9, 1'b1, 1'b1);
    check("rs_icount", 32'(icount), 32'd9);
    check("rs_indone", 32'(indone), 32'd0);
    check("rs_busy", 32'(inner_busy), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("rs_step_icount", 32'(icount), 32'd8);
    // Plain restart proves the reload register captured 9.
    drive(1'b0, '0, 1'b1, 1'b0);
    check("rs_reload_icount", 32'(icount), 32'd9);
    repeat (9) drive(1'b0, '0, 1'b0, 1'b1);
    check("rs_end_indone", 32'(indone), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("rs_pulses", 32'(done_pulses - base), 32'd1);

    // Zero count: 65536 steps.
    base = done_pulses;
    drive(1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("zero_start_icount", 32'(icount), 32'd0);
    check("zero_start_busy", 32'(inner_busy), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("zero_wrap_icount", 32'(icount), 32'hFFFF);
    check("zero_wrap_busy", 32'(inner_busy), 32'd1);
    repeat (65534) drive(1'b0, '0, 1'b0, 1'b1);
    check("zero_last_icount", 32'(icount), 32'd1);
    check("zero_last_ilast", 32'(ilast), 32'd1);
    check("zero_mid_pulses", 32'(done_pulses - base), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("zero_end_indone", 32'(indone), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("zero_pulses", 32'(done_pulses - base), 32'd1);

`ifdef INNER_CTL_STAT_EN
    drive(1'b1, 16'd6, 1'b1, 1'b0);
    statrd = 1'b1;
    #1;
    check("stat_oe", 32'(gpu_dout_oe), 32'd1);
    check("stat_dout", 32'(gpu_dout_out), 32'd6);
    statrd = 1'b0;
    #1;
    check("stat_oe_off", 32'(gpu_dout_oe), 32'd0);
`endif

    // Async reset mid-pass at icount = 2.
    base = done_pulses;
    drive(1'b1, 16'd5, 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b1);
    check("ar_pre_icount", 32'(icount), 32'd2);
    #1;
    reset_n = 1'b0;
    #1;
    check("ar_icount", 32'(icount), 32'd0);
    check("ar_busy", 32'(inner_busy), 32'd0);
    check("ar_indone", 32'(indone), 32'd0);
    check("ar_ilast", 32'(ilast), 32'd0);
    #10;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) drive(1'b0, '0, 1'b0, 1'b1);
    check("ar_post_busy", 32'(inner_busy), 32'd0);
    check("ar_post_icount", 32'(icount), 32'd0);
    check("ar_pulses", 32'(done_pulses - base), 32'd0);
    // Reset cleared the reload register: a start now yields a 0 count.
    drive(1'b0, '0, 1'b1, 1'b0);
    check("ar_reload_zero", 32'(icount), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inner_ctl.md
Name: inner_ctl

Overview:
- Inner-loop controller for the blitter, sitting directly downstream of the outer-loop sequencer.
- Holds the inner (pixels-per-line) count loaded by the GPU.
- Reloads a working counter on each `instart` pulse and decrements it once per pixel `step`.
- Returns a one-cycle `indone` to the outer sequencer when the line completes.
- Also provides `inner_busy` and a read-back of the live count.

Parameters:
- CW, 16, width of inner count register and working counter.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `gpu_din`  in  CW  GPU write data, inner count field (bits CW-1..0 of the count register).
- `countld`  in  1  load strobe for the inner count reload register.
- `instart`  in  1  start/restart an inner pass (from outer sequencer).
- `step`  in  1  one pixel completed by the datapath this cycle.
- `indone`  out  1  registered one-cycle pulse: inner pass complete.
- `inner_busy`  out  1  high while an inner pass is in progress.
- `icount`  out  CW  live working counter value.
- `ilast`  out  1  combinational: `inner_busy` & (`icount` == 1); the next `step` completes the pass.

Behaviour:
- Reset (async, `reset_n`=0):
  - ireload=0, `icount`=0, `inner_busy`=0, `indone`=0.
  - Reset mid-pass aborts silently; no `indone` is produced.
- States:
  - IDLE: `inner_busy`=0.
  - RUN: `inner_busy`=1.
- ireload: loads `gpu_din` on any edge with `countld`=1, in either state.
- `instart`=1 (any state):
  - `icount` <= effective reload value; state -> RUN.
  - If `countld` is also high that cycle, the effective reload value is `gpu_din` (bypass); otherwise it is ireload.
  - `instart` while RUN restarts the pass. The pending `step` that cycle is ignored and no `indone` is generated for the aborted pass.
- Zero count: reload value 0 means 2^CW steps. The counter wraps 0 -> all-ones on the first step and finishes when it is 1 and stepped.
- RUN, `step`=1, `icount` != 1: `icount` <= `icount` - 1 (mod 2^CW).
- RUN, `step`=1, `icount` == 1:
  - `icount` <= 0, state -> IDLE.
  - `indone` <= 1 at the same edge, so `indone` is high for exactly the following cycle.
- IDLE, `step`=1: ignored; `icount` unchanged.
- `indone` is 0 in every cycle except the one following the completing step.
- `indone` and a new `instart` in the same cycle are legal. The outer sequencer issues the next `instart` combinationally from `indone`; the pass restarts with no dead cycle.
- Latency:
  - `instart` to `inner_busy`=1: 1 cycle.
  - Final `step` to `indone`: 1 cycle.
  - Count of N: N `step`s yields exactly one `indone`.
- `step` gaps (datapath stalls) are allowed; the counter holds.

Optional Feature:
- Macro: `INNER_CTL_STAT_EN`.
- When defined:
  - Adds input `statrd` and outputs `gpu_dout_out` [CW] / `gpu_dout_oe` [1].
  - `gpu_dout_out` = `icount`.
  - `gpu_dout_oe` = `statrd`.
  - Tristate-style status read-back of the live inner count onto the GPU bus, combinational.
- When undefined: these ports do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - `step` pulsed 5x with no `instart` -> `icount`=0, `inner_busy`=0, `indone` never high.
- Basic pass:
  - `countld` with `gpu_din`=3, then `instart`, then 3 consecutive `step`s.
  - Expected: `icount` 3,2,1,0; `ilast` high while `icount`=1; `indone` high exactly 1 cycle after the 3rd step; `inner_busy` low from then on.
- Stalled pass:
  - count=4, `step` pattern 1,0,0,1,1,0,1 -> `indone` 1 cycle after the 7th pattern cycle, exactly one pulse.
- Back-to-back lines:
  - count=2, `instart` asserted in the same cycle `indone` is high, repeated 3x.
  - Expected: 3 `indone` pulses spaced 3 cycles apart (2 steps + restart edge), no dead cycle.
- Restart and bypass:
  - During a pass with `icount`=5, assert `instart`+`countld`+`step` with `gpu_din`=9.
  - Expected: `icount`=9 next cycle; no `indone` for the aborted pass; ireload=9.
- Zero count and async reset:
  - ireload=0, `instart`, 65536 steps -> `indone` once.
  - Separately, drop `reset_n` mid-pass at `icount`=2 -> all outputs 0 immediately; no `indone` after release.
